// File: rtl/proc_cfg_sequencer_if.sv
// Valid/ready byte-stream link used on both sides of the sequencer.
// The master drives valid/data; the slave drives ready.
interface proc_cfg_sequencer_if #(
    parameter int DW = 8
);
    logic          valid;
    logic [DW-1:0] data;
    logic          ready;

    modport master (
        output valid,
        output data,
        input  ready
    );

    modport slave (
        input  valid,
        input  data,
        output ready
    );
endinterface

// File: rtl/proc_cfg_sequencer.sv
// Frame-boundary reconfiguration sequencer for the pixel processor register bus.
// Optional readback check enabled by defining PROC_CFG_VERIFY_EN.
module proc_cfg_sequencer #(
    parameter  int IMG_WIDTH  = 32,
    parameter  int IMG_HEIGHT = 32,
    localparam int FRAME_PIX  = IMG_WIDTH * IMG_HEIGHT,
    localparam int CW         = $clog2(FRAME_PIX)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 cfg_req,
    input  logic [1:0]           cfg_mode,
    input  logic [71:0]          cfg_kernel,
    output logic                 cfg_busy,
    output logic                 cfg_done,
    output logic                 cfg_err,
    proc_cfg_sequencer_if.slave  s,
    proc_cfg_sequencer_if.master p,
    output logic                 reg_write_en,
    output logic [4:0]           reg_addr,
    output logic [7:0]           reg_wdata,
    input  logic [7:0]           reg_rdata,
    output logic [CW-1:0]        pix_cnt
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_PEND   = 3'd1,
        S_WRITE  = 3'd2,
`ifdef PROC_CFG_VERIFY_EN
        S_VERIFY = 3'd3,
`endif
        S_DONE   = 3'd4
    } state_t;

    state_t        r_state;
    logic [3:0]    r_idx;
    logic [1:0]    r_mode;
    logic [71:0]   r_kernel;
    logic [CW-1:0] r_cnt;
    logic          r_busy;
    logic          r_done;
    logic          r_we;
    logic [4:0]    r_addr;
    logic [7:0]    r_wdata;

    logic          w_bound;
    logic          w_gate;
    logic          w_sready;
    logic          w_beat;

    // idx 0..8 are kernel taps, 9 is the mode register, 10 the ID register
    function automatic logic [4:0] f_addr(input logic [3:0] idx);
        unique case (1'b1)
            (idx < 4'd9):  return 5'h04 + {1'b0, idx};
            (idx == 4'd9): return 5'h00;
            default:       return 5'h10;
        endcase
    endfunction

    function automatic logic [7:0] f_byte(
        input logic [3:0]  idx,
        input logic [71:0] k,
        input logic [1:0]  m
    );
        case (idx)
            4'd0:    return k[7:0];
            4'd1:    return k[15:8];
            4'd2:    return k[23:16];
            4'd3:    return k[31:24];
            4'd4:    return k[39:32];
            4'd5:    return k[47:40];
            4'd6:    return k[55:48];
            4'd7:    return k[63:56];
            4'd8:    return k[71:64];
            4'd9:    return {6'b0, m};
            4'd10:   return 8'hAA;
            default: return 8'h00;
        endcase
    endfunction

    assign w_bound = (r_cnt == '0);

    always_comb begin
        w_gate = 1'b0;
        case (r_state)
            S_IDLE:   w_gate = 1'b0;
            S_PEND:   w_gate = w_bound;
            S_WRITE:  w_gate = 1'b1;
`ifdef PROC_CFG_VERIFY_EN
            S_VERIFY: w_gate = 1'b1;
`endif
            S_DONE:   w_gate = 1'b1;
            default:  w_gate = 1'b0;
        endcase
    end

    assign w_sready = p.ready && !w_gate;
    assign w_beat   = s.valid && w_sready;

    assign s.ready  = w_sready;
    assign p.valid  = s.valid && !w_gate;
    assign p.data   = s.data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_beat) begin
            r_cnt <= (r_cnt == CW'(FRAME_PIX - 1)) ? '0 : r_cnt + 1'b1;
        end
    end

`ifdef PROC_CFG_VERIFY_EN
    logic r_err;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_idx    <= '0;
            r_mode   <= '0;
            r_kernel <= '0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
`ifdef PROC_CFG_VERIFY_EN
            r_err    <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_done <= 1'b0;
                    if (cfg_req) begin
                        r_mode   <= cfg_mode;
                        r_kernel <= cfg_kernel;
                        r_busy   <= 1'b1;
                        r_state  <= S_PEND;
`ifdef PROC_CFG_VERIFY_EN
                        r_err    <= 1'b0;
`endif
                    end
                end
                S_PEND: begin
                    if (w_bound) begin
                        r_state <= S_WRITE;
                        r_idx   <= '0;
                        r_we    <= 1'b1;
                        r_addr  <= f_addr(4'd0);
                        r_wdata <= f_byte(4'd0, r_kernel, r_mode);
                    end
                end
                S_WRITE: begin
                    if (r_idx == 4'd9) begin
                        r_we    <= 1'b0;
                        r_idx   <= '0;
                        r_wdata <= '0;
`ifdef PROC_CFG_VERIFY_EN
                        r_state <= S_VERIFY;
                        r_addr  <= f_addr(4'd0);
`else
                        r_state <= S_DONE;
                        r_addr  <= '0;
                        r_done  <= 1'b1;
`endif
                    end else begin
                        r_idx   <= r_idx + 4'd1;
                        r_addr  <= f_addr(r_idx + 4'd1);
                        r_wdata <= f_byte(r_idx + 4'd1, r_kernel, r_mode);
                    end
                end
`ifdef PROC_CFG_VERIFY_EN
                S_VERIFY: begin
                    // reg_rdata is combinational on reg_addr, so compare this cycle
                    if (reg_rdata != f_byte(r_idx, r_kernel, r_mode)) begin
                        r_err <= 1'b1;
                    end
                    if (r_idx == 4'd10) begin
                        r_state <= S_DONE;
                        r_addr  <= '0;
                        r_done  <= 1'b1;
                    end else begin
                        r_idx  <= r_idx + 4'd1;
                        r_addr <= f_addr(r_idx + 4'd1);
                    end
                end
`endif
                S_DONE: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

`ifdef PROC_CFG_VERIFY_EN
    assign cfg_err = r_err;
`else
    logic w_unused_rdata;
    assign w_unused_rdata = ^reg_rdata;
    assign cfg_err        = 1'b0;
`endif

    assign cfg_busy     = r_busy;
    assign cfg_done     = r_done;
    assign reg_write_en = r_we;
    assign reg_addr     = r_addr;
    assign reg_wdata    = r_wdata;
    assign pix_cnt      = r_cnt;

endmodule

// File: tb/tb_proc_cfg_sequencer.sv
// Self-checking bench for proc_cfg_sequencer: stream gating table,
// register-write scoreboard and multi-cycle sequences.
module tb_proc_cfg_sequencer;

    localparam int FRAME_PIX = 1024;
`ifdef PROC_CFG_VERIFY_EN
    localparam int LAT = 22;
`else
    localparam int LAT = 11;
`endif

    logic        clk;
    logic        rst;
    logic        cfg_req;
    logic [1:0]  cfg_mode;
    logic [71:0] cfg_kernel;
    logic        cfg_busy;
    logic        cfg_done;
    logic        cfg_err;
    logic        reg_write_en;
    logic [4:0]  reg_addr;
    logic [7:0]  reg_wdata;
    logic [7:0]  reg_rdata;
    logic [9:0]  pix_cnt;

    proc_cfg_sequencer_if s_if ();
    proc_cfg_sequencer_if p_if ();

    proc_cfg_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .cfg_req      (cfg_req),
        .cfg_mode     (cfg_mode),
        .cfg_kernel   (cfg_kernel),
        .cfg_busy     (cfg_busy),
        .cfg_done     (cfg_done),
        .cfg_err      (cfg_err),
        .s            (s_if),
        .p            (p_if),
        .reg_write_en (reg_write_en),
        .reg_addr     (reg_addr),
        .reg_wdata    (reg_wdata),
        .reg_rdata    (reg_rdata),
        .pix_cnt      (pix_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // processor register file model; 0x10 is a fixed ID register
    logic [7:0] regs [32];
    logic [7:0] id_reg;
    assign reg_rdata = (reg_addr == 5'h10) ? id_reg : regs[reg_addr];

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) regs[i] <= 8'h00;
        end else if (reg_write_en) begin
            regs[reg_addr] <= reg_wdata;
        end
    end

    int n_vec = 0;
    int n_err = 0;
    int n_writes = 0;
    int n_done = 0;

    typedef struct {
        logic [4:0] addr;
        logic [7:0] data;
    } wr_t;
    wr_t sb [$];

    typedef struct {
        logic       sv;
        logic       pr;
        logic [7:0] sd;
        logic       pv;
        logic       sr;
        logic       beat;
    } vec_t;
    vec_t vt [6];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic void push_cfg(input logic [1:0] m, input logic [71:0] k);
        wr_t e;
        for (int i = 0; i < 9; i++) begin
            e.addr = 5'(4 + i);
            e.data = k[i*8 +: 8];
            sb.push_back(e);
        end
        e.addr = 5'h00;
        e.data = {6'b0, m};
        sb.push_back(e);
    endfunction

    // write monitor, sampled just before each rising edge
    always @(negedge clk) begin
        #4;
        if (!rst && reg_write_en) begin
            n_writes++;
            chk("wr_sready_gated", {31'b0, s_if.ready}, 32'd0);
            chk("wr_pvalid_gated", {31'b0, p_if.valid}, 32'd0);
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_write: addr %0h data %0h, none expected",
                         reg_addr, reg_wdata);
            end else begin
                wr_t e;
                e = sb.pop_front();
                chk("wr_addr", {27'b0, reg_addr}, {27'b0, e.addr});
                chk("wr_data", {24'b0, reg_wdata}, {24'b0, e.data});
            end
        end
        if (cfg_done) n_done++;
    end

    task automatic request(input logic [1:0] m, input logic [71:0] k);
        @(negedge clk);
        cfg_mode   = m;
        cfg_kernel = k;
        cfg_req    = 1'b1;
        push_cfg(m, k);
        @(negedge clk);
        cfg_req = 1'b0;
    endtask

    task automatic wait_done(output int cyc);
        cyc = 0;
        while (cfg_done !== 1'b1 && cyc < 200) begin
            @(negedge clk);
            cyc++;
        end
        chk("done_seen", {31'b0, cfg_done}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int cyc, dc, beats, wrap, fw, nw0, nd0, g;
        int exp_cnt;

        vt[0] = '{1'b1, 1'b1, 8'h3C, 1'b1, 1'b1, 1'b1};
        vt[1] = '{1'b1, 1'b0, 8'hA5, 1'b1, 1'b0, 1'b0};
        vt[2] = '{1'b0, 1'b1, 8'h5A, 1'b0, 1'b1, 1'b0};
        vt[3] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0};
        vt[4] = '{1'b1, 1'b1, 8'hFF, 1'b1, 1'b1, 1'b1};
        vt[5] = '{1'b1, 1'b0, 8'h81, 1'b1, 1'b0, 1'b0};

        rst        = 1'b1;
        cfg_req    = 1'b0;
        cfg_mode   = 2'b00;
        cfg_kernel = '0;
        s_if.valid = 1'b0;
        s_if.data  = 8'h00;
        p_if.ready = 1'b0;
        id_reg     = 8'hAA;

        // reset state
        repeat (2) @(negedge clk);
        chk("rst_busy", {31'b0, cfg_busy}, 32'd0);
        chk("rst_done", {31'b0, cfg_done}, 32'd0);
        chk("rst_err", {31'b0, cfg_err}, 32'd0);
        chk("rst_we", {31'b0, reg_write_en}, 32'd0);
        chk("rst_addr", {27'b0, reg_addr}, 32'd0);
        chk("rst_wdata", {24'b0, reg_wdata}, 32'd0);
        chk("rst_cnt", {22'b0, pix_cnt}, 32'd0);
        rst = 1'b0;

        // request at a frame boundary, stream held off throughout
        @(negedge clk);
        cfg_mode   = 2'b10;
        cfg_kernel = {9{8'h01}};
        cfg_req    = 1'b1;
        push_cfg(2'b10, {9{8'h01}});
        #1 chk("t1_idle_busy", {31'b0, cfg_busy}, 32'd0);
        @(negedge clk);
        cfg_req    = 1'b0;
        s_if.valid = 1'b1;
        s_if.data  = 8'h77;
        p_if.ready = 1'b1;
        cyc = 0;
        dc  = -1;
        while (cyc < 60 && dc < 0) begin
            #1;
            chk("t1_sready", {31'b0, s_if.ready}, 32'd0);
            chk("t1_pvalid", {31'b0, p_if.valid}, 32'd0);
            chk("t1_busy", {31'b0, cfg_busy}, 32'd1);
            if (cfg_done) dc = cyc;
            else begin
                @(negedge clk);
                cyc++;
            end
        end
        chk("t1_latency", dc, LAT);
        chk("t1_err", {31'b0, cfg_err}, 32'd0);
        @(negedge clk);
        s_if.valid = 1'b0;
        #1;
        chk("t1_idle_busy2", {31'b0, cfg_busy}, 32'd0);
        chk("t1_idle_done", {31'b0, cfg_done}, 32'd0);
        chk("t1_ungated", {31'b0, s_if.ready}, 32'd1);
        chk("t1_cnt", {22'b0, pix_cnt}, 32'd0);
        chk("t1_sb_empty", sb.size(), 0);

        // stream gating table in IDLE
        exp_cnt = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("tbl_cnt", {22'b0, pix_cnt}, exp_cnt);
            s_if.valid = vt[i].sv;
            p_if.ready = vt[i].pr;
            s_if.data  = vt[i].sd;
            #1;
            chk("tbl_pvalid", {31'b0, p_if.valid}, {31'b0, vt[i].pv});
            chk("tbl_sready", {31'b0, s_if.ready}, {31'b0, vt[i].sr});
            chk("tbl_pdata", {24'b0, p_if.data}, {24'b0, vt[i].sd});
            exp_cnt += int'(vt[i].beat);
        end
        @(negedge clk);
        chk("tbl_cnt_end", {22'b0, pix_cnt}, exp_cnt);

        // mid-frame request at pix_cnt=5 with a continuous stream
        s_if.valid = 1'b1;
        p_if.ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("t2_start_cnt", {22'b0, pix_cnt}, 32'd5);
        cfg_mode   = 2'b01;
        cfg_kernel = 72'h11_22_33_44_55_66_77_88_99;
        cfg_req    = 1'b1;
        push_cfg(2'b01, 72'h11_22_33_44_55_66_77_88_99);
        cyc   = 0;
        beats = 0;
        wrap  = -1;
        fw    = -1;
        dc    = -1;
        while (cyc < 1200 && dc < 0) begin
            #4;
            if (s_if.valid && s_if.ready) begin
                beats++;
                if (pix_cnt == 10'(FRAME_PIX - 1)) wrap = cyc;
            end
            if (reg_write_en && fw < 0) fw = cyc;
            if (cfg_done) dc = cyc;
            @(negedge clk);
            cyc++;
            cfg_req = 1'b0;
        end
        s_if.valid = 1'b0;
        chk("t2_beats", beats, 1019);
        chk("t2_wrap_cyc", wrap, 1018);
        chk("t2_first_write", fw, 1020);
        chk("t2_done_cyc", dc, 1020 + LAT - 1);
        #1;
        chk("t2_cnt_end", {22'b0, pix_cnt}, 32'd0);
        chk("t2_ungated", {31'b0, s_if.ready}, 32'd1);
        chk("t2_busy", {31'b0, cfg_busy}, 32'd0);

        // second request while busy is dropped
        nw0 = n_writes;
        nd0 = n_done;
        request(2'b01, 72'h09_08_07_06_05_04_03_02_01);
        repeat (4) @(negedge clk);
        cfg_mode = 2'b11;
        cfg_req  = 1'b1;
        @(negedge clk);
        cfg_req = 1'b0;
        wait_done(cyc);
        repeat (5) @(negedge clk);
        chk("t3_writes", n_writes - nw0, 10);
        chk("t3_dones", n_done - nd0, 1);
        chk("t3_sb_empty", sb.size(), 0);
        chk("t3_busy", {31'b0, cfg_busy}, 32'd0);

        // reset in the middle of the write burst
        request(2'b00, 72'hF0_E0_D0_C0_B0_A0_90_80_70);
        g = 0;
        while (!(reg_write_en && reg_addr == 5'h08) && g < 40) begin
            @(negedge clk);
            g++;
        end
        chk("t4_reach_idx4", {27'b0, reg_addr}, 32'h08);
        #1 rst = 1'b1;
        #1;
        chk("t4_we_async", {31'b0, reg_write_en}, 32'd0);
        chk("t4_busy_async", {31'b0, cfg_busy}, 32'd0);
        @(posedge clk);
        #1;
        chk("t4_we_edge", {31'b0, reg_write_en}, 32'd0);
        chk("t4_cnt", {22'b0, pix_cnt}, 32'd0);
        chk("t4_done", {31'b0, cfg_done}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        sb.delete();
        nw0 = n_writes;
        nd0 = n_done;
        repeat (15) @(negedge clk);
        chk("t4_no_writes", n_writes - nw0, 0);
        chk("t4_no_done", n_done - nd0, 0);
        chk("t4_idle", {31'b0, cfg_busy}, 32'd0);
        chk("t4_addr_idle", {27'b0, reg_addr}, 32'd0);

`ifdef PROC_CFG_VERIFY_EN
        // readback mismatch on the ID register
        id_reg = 8'h55;
        request(2'b10, 72'h01_02_03_04_05_06_07_08_09);
        wait_done(cyc);
        chk("t5_err_at_done", {31'b0, cfg_err}, 32'd1);
        @(negedge clk);
        chk("t5_err_sticky", {31'b0, cfg_err}, 32'd1);
        id_reg = 8'hAA;
        request(2'b00, 72'h01_02_03_04_05_06_07_08_09);
        chk("t5_err_cleared", {31'b0, cfg_err}, 32'd0);
        wait_done(cyc);
        chk("t5_err_clean", {31'b0, cfg_err}, 32'd0);
        @(negedge clk);
`else
        chk("t5_err_tied", {31'b0, cfg_err}, 32'd0);
`endif

        chk("final_sb_empty", sb.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
